// File: rtl/rd_tag_tracker_pkg.sv
// Shared defaults and types for the read-request tag tracker.
package rd_tag_pkg;

    localparam int MAX_OUTSTANDING = 64;
    localparam int TAG_BITS        = $clog2(MAX_OUTSTANDING);

    typedef logic [TAG_BITS-1:0] t_tag;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } t_state;

endpackage

// File: rtl/rd_tag_tracker_if.sv
// Request, c0 channel and return-path signals of the read tag tracker.
interface rd_tag_tracker_if #(
    parameter int ID_BITS    = 4,
    parameter int ADDR_BITS  = 48,
    parameter int DATA_BITS  = 512,
    parameter int MDATA_BITS = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_BITS-1:0]  in_addr;
    logic [ID_BITS-1:0]    in_id;

    logic                  req_rd_en;
    logic                  req_rd_available;
    logic [ADDR_BITS-1:0]  req_rd_addr;
    logic [MDATA_BITS-1:0] req_rd_mdata;

    logic                  resp_rd_valid;
    logic [DATA_BITS-1:0]  resp_rd_data;
    logic [MDATA_BITS-1:0] resp_rd_mdata;

    logic                  out_valid;
    logic [DATA_BITS-1:0]  out_data;
    logic [ID_BITS-1:0]    out_id;

    modport slave (
        input  in_valid, in_addr, in_id, req_rd_available,
               resp_rd_valid, resp_rd_data, resp_rd_mdata,
        output in_ready, req_rd_en, req_rd_addr, req_rd_mdata,
               out_valid, out_data, out_id
    );

    modport master (
        output in_valid, in_addr, in_id, req_rd_available,
               resp_rd_valid, resp_rd_data, resp_rd_mdata,
        input  in_ready, req_rd_en, req_rd_addr, req_rd_mdata,
               out_valid, out_data, out_id
    );
endinterface

// File: rtl/rd_tag_tracker_freelist.sv
// Circular FIFO holding the free mdata tags; push and pop may coincide.
module rd_tag_freelist #(
    parameter int  DEPTH = rd_tag_pkg::MAX_OUTSTANDING,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    output logic [TW-1:0] head_tag,
    output logic [TW:0]   count
);
    logic [TW-1:0] mem_r [DEPTH];
    logic [TW-1:0] rd_ptr_r;
    logic [TW-1:0] wr_ptr_r;
    logic [TW:0]   count_r;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {TW{1'b0}};
            wr_ptr_r <= {TW{1'b0}};
            count_r  <= {(TW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + TW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + TW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (TW+1)'(1);
                2'b01:   count_r <= count_r - (TW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag storage; entries are only read after they have been written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_tag;
        end
    end

    assign head_tag = mem_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/rd_tag_tracker.sv
// Read tag tracker: tags c0 read requests from a pooled free list and
// routes each response back with the requester ID it was issued under.
module rd_tag_tracker #(
    parameter int  MAX_OUTSTANDING = rd_tag_pkg::MAX_OUTSTANDING,
    parameter int  ID_BITS         = 4,
    parameter int  ADDR_BITS       = 48,
    parameter int  DATA_BITS       = 512,
    parameter int  MDATA_BITS      = 16,
    localparam int TW              = $clog2(MAX_OUTSTANDING)
) (
    input  logic                clk,
    input  logic                reset,
    rd_tag_tracker_if.slave     bus,
    output logic [TW:0]         outstanding,
    output logic                init_done,
    output logic                err_spurious
);
    import rd_tag_pkg::*;

    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(63);

    t_state                 state_r;
    logic [TW-1:0]          init_cnt_r;
    logic                   init_done_r;
    logic [MAX_OUTSTANDING-1:0] busy_r;
    logic [ID_BITS-1:0]     id_table_r [MAX_OUTSTANDING];

    logic                   req_rd_en_r;
    logic [ADDR_BITS-1:0]   req_rd_addr_r;
    logic [MDATA_BITS-1:0]  req_rd_mdata_r;
    logic                   out_valid_r;
    logic [DATA_BITS-1:0]   out_data_r;
    logic [ID_BITS-1:0]     out_id_r;
    logic [TW:0]            outstanding_r;
    logic                   err_spurious_r;

    logic [TW-1:0]          head_tag_s;
    logic [TW-1:0]          resp_tag_s;
    logic [TW-1:0]          push_tag_s;
    logic [TW:0]            free_count_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   resp_ok_s;
    logic                   resp_bad_s;
    logic                   push_s;

    // Handshake and response qualification; during INIT the free list is fed by the counter
    always_comb begin
        resp_tag_s = bus.resp_rd_mdata[TW-1:0];
        in_ready_s = (state_r == ST_RUN) && bus.req_rd_available &&
                     (free_count_s != {(TW+1){1'b0}});
        accept_s   = bus.in_valid && in_ready_s;
        resp_ok_s  = bus.resp_rd_valid && busy_r[resp_tag_s] &&
                     (bus.resp_rd_mdata[MDATA_BITS-1:TW] == {(MDATA_BITS-TW){1'b0}});
        resp_bad_s = bus.resp_rd_valid && !resp_ok_s;
        if (state_r == ST_INIT) begin
            push_s     = 1'b1;
            push_tag_s = init_cnt_r;
        end else begin
            push_s     = resp_ok_s;
            push_tag_s = resp_tag_s;
        end
    end

    rd_tag_freelist #(.DEPTH(MAX_OUTSTANDING)) u_freelist (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .push_tag (push_tag_s),
        .pop      (accept_s),
        .head_tag (head_tag_s),
        .count    (free_count_s)
    );

    // Free-list population sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= {TW{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + TW'(1);
                    if (init_cnt_r == TW'(MAX_OUTSTANDING - 1)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // In-flight bookkeeping: a popped tag is never busy, so set and clear never collide
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= {MAX_OUTSTANDING{1'b0}};
            id_table_r <= '{default: {ID_BITS{1'b0}}};
        end else begin
            if (accept_s) begin
                busy_r[head_tag_s]     <= 1'b1;
                id_table_r[head_tag_s] <= bus.in_id;
            end
            if (resp_ok_s) begin
                busy_r[resp_tag_s] <= 1'b0;
            end
        end
    end

    // Registered request, return and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            req_rd_en_r    <= 1'b0;
            req_rd_addr_r  <= {ADDR_BITS{1'b0}};
            req_rd_mdata_r <= {MDATA_BITS{1'b0}};
            out_valid_r    <= 1'b0;
            out_data_r     <= {DATA_BITS{1'b0}};
            out_id_r       <= {ID_BITS{1'b0}};
            outstanding_r  <= {(TW+1){1'b0}};
            err_spurious_r <= 1'b0;
        end else begin
            req_rd_en_r <= accept_s;
            if (accept_s) begin
                req_rd_addr_r  <= bus.in_addr & LINE_MASK;
                req_rd_mdata_r <= MDATA_BITS'(head_tag_s);
            end
            out_valid_r <= resp_ok_s;
            if (resp_ok_s) begin
                out_data_r <= bus.resp_rd_data;
                out_id_r   <= id_table_r[resp_tag_s];
            end
            if (resp_bad_s) begin
                err_spurious_r <= 1'b1;
            end
            case ({accept_s, resp_ok_s})
                2'b10:   outstanding_r <= outstanding_r + (TW+1)'(1);
                2'b01:   outstanding_r <= outstanding_r - (TW+1)'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.req_rd_en    = req_rd_en_r;
    assign bus.req_rd_addr  = req_rd_addr_r;
    assign bus.req_rd_mdata = req_rd_mdata_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_id       = out_id_r;
    assign outstanding      = outstanding_r;
    assign init_done        = init_done_r;
    assign err_spurious     = err_spurious_r;

endmodule

// File: tb/tb_rd_tag_tracker.sv
// Bench for rd_tag_tracker: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_rd_tag_tracker;
    localparam int M          = 64;
    localparam int ID_BITS    = 4;
    localparam int ADDR_BITS  = 48;
    localparam int DATA_BITS  = 512;
    localparam int MDATA_BITS = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] outstanding;
    logic       init_done;
    logic       err_spurious;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rd_tag_tracker_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
                        .DATA_BITS(DATA_BITS), .MDATA_BITS(MDATA_BITS)) bus ();

    rd_tag_tracker #(.MAX_OUTSTANDING(M), .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
                     .DATA_BITS(DATA_BITS), .MDATA_BITS(MDATA_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .outstanding  (outstanding),
        .init_done    (init_done),
        .err_spurious (err_spurious)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int             m_free[$];
    bit             m_busy[M];
    int             m_id[M];
    bit             m_run, m_started, m_in_rst;
    int             m_init_cnt, m_last_tag;
    bit             e_req_en, e_out_valid, e_err;
    logic [47:0]    e_req_addr;
    int             e_req_mdata, e_out_id;
    logic [511:0]   e_out_data;

    initial forever begin
        bit acc, rok;
        int rtag, t;
        @(posedge clk);
        m_started = 1'b1;
        if (reset) begin
            m_free.delete();
            foreach (m_busy[i]) begin m_busy[i] = 1'b0; m_id[i] = 0; end
            m_run = 1'b0; m_init_cnt = 0; m_in_rst = 1'b1;
            e_req_en = 1'b0; e_req_addr = '0; e_req_mdata = 0;
            e_out_valid = 1'b0; e_out_data = '0; e_out_id = 0; e_err = 1'b0;
        end else begin
            m_in_rst = 1'b0;
            acc  = bus.in_valid && m_run && bus.req_rd_available && (m_free.size() != 0);
            rtag = int'(bus.resp_rd_mdata) % M;
            rok  = bus.resp_rd_valid && (int'(bus.resp_rd_mdata) < M) && m_busy[rtag];
            e_req_en = acc;
            if (acc) begin
                t = m_free.pop_front();
                m_busy[t] = 1'b1;
                m_id[t] = int'(bus.in_id);
                m_last_tag = t;
                e_req_addr = (bus.in_addr / 64) * 64;
                e_req_mdata = t;
            end
            e_out_valid = rok;
            if (rok) begin
                e_out_data = bus.resp_rd_data;
                e_out_id = m_id[rtag];
                m_busy[rtag] = 1'b0;
                m_free.push_back(rtag);
            end
            if (bus.resp_rd_valid && !rok) e_err = 1'b1;
            if (!m_run) begin
                m_free.push_back(m_init_cnt);
                m_init_cnt++;
                if (m_init_cnt == M) m_run = 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (m_started) begin
            chk("in_ready", bus.in_ready, m_run && bus.req_rd_available && (m_free.size() != 0));
            chk("req_rd_en", bus.req_rd_en, e_req_en);
            if (e_req_en || m_in_rst) begin
                chk("req_rd_addr", bus.req_rd_addr, e_req_addr);
                chk("req_rd_mdata", bus.req_rd_mdata, e_req_mdata);
            end
            chk("out_valid", bus.out_valid, e_out_valid);
            if (e_out_valid || m_in_rst) begin
                chk("out_data", bus.out_data, e_out_data);
                chk("out_id", bus.out_id, e_out_id);
            end
            chk("outstanding", outstanding, m_run ? (M - m_free.size()) : 0);
            chk("init_done", init_done, m_run);
            chk("err_spurious", err_spurious, e_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        repeat (M - 1) step();
        chk("init_done_early", init_done, 1'b0);
        step();
        chk("init_done_at_64", init_done, 1'b1);
        chk("init_outstanding", outstanding, 0);
        chk("init_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic issue(input logic [47:0] a, input int id);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_id    = 4'(id);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic respond(input int mdata);
        bus.resp_rd_valid = 1'b1;
        bus.resp_rd_mdata = 16'(mdata);
        bus.resp_rd_data  = rand_line();
        step();
        bus.resp_rd_valid = 1'b0;
    endtask

    initial begin
        logic [47:0] exp_addr [4];
        int resp_order [4];
        int exp_ids [4];
        exp_addr   = '{48'h1000, 48'h1040, 48'h1080, 48'h10C0};
        resp_order = '{3, 0, 2, 1};
        exp_ids    = '{4, 1, 3, 2};

        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_id = '0;
        bus.req_rd_available = 1'b1;
        bus.resp_rd_valid = 1'b0; bus.resp_rd_data = '0; bus.resp_rd_mdata = '0;

        repeat (3) step();
        chk("reset_outstanding", outstanding, 0);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        reset = 1'b0;
        wait_init();

        // Four back-to-back requests; low offset bits must be dropped
        for (int k = 0; k < 4; k++) begin
            issue(exp_addr[k] + 48'(k), k + 1);
            chk("issue_en", bus.req_rd_en, 1'b1);
            chk("issue_tag", bus.req_rd_mdata, k);
            chk("issue_addr", bus.req_rd_addr, exp_addr[k]);
        end
        chk("outstanding_4", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            respond(resp_order[i]);
            chk("resp_valid", bus.out_valid, 1'b1);
            chk("resp_id", bus.out_id, exp_ids[i]);
        end
        chk("outstanding_back_0", outstanding, 0);

        // Exhaustion
        for (int i = 0; i < M; i++) issue(48'h4000 + 48'(64 * i), i % 16);
        chk("exhaust_outstanding", outstanding, M);
        chk("exhaust_ready", bus.in_ready, 1'b0);
        issue(48'h9000, 3);
        chk("exhaust_no_issue", bus.req_rd_en, 1'b0);
        respond(7);
        chk("exhaust_ready_again", bus.in_ready, 1'b1);
        issue(48'h8000, 9);
        chk("exhaust_reissue_en", bus.req_rd_en, 1'b1);
        chk("exhaust_reuse_tag", bus.req_rd_mdata, 7);
        for (int t = 0; t < M; t++) respond(t);
        chk("drain_outstanding", outstanding, 0);
        chk("drain_no_err", err_spurious, 1'b0);

        // Backpressure
        bus.req_rd_available = 1'b0;
        bus.in_valid = 1'b1; bus.in_addr = 48'h5000; bus.in_id = 4'd5;
        repeat (5) begin
            step();
            chk("bp_no_issue", bus.req_rd_en, 1'b0);
            chk("bp_not_ready", bus.in_ready, 1'b0);
        end
        chk("bp_no_tag_used", outstanding, 0);
        bus.req_rd_available = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp_release_issue", bus.req_rd_en, 1'b1);
        chk("bp_release_addr", bus.req_rd_addr, 48'h5000);
        chk("bp_outstanding", outstanding, 1);

        // Accept and response in the same cycle
        bus.in_valid = 1'b1; bus.in_addr = 48'h6000; bus.in_id = 4'd6;
        bus.resp_rd_valid = 1'b1; bus.resp_rd_mdata = 16'(m_last_tag);
        bus.resp_rd_data = rand_line();
        step();
        bus.in_valid = 1'b0; bus.resp_rd_valid = 1'b0;
        chk("simul_outstanding", outstanding, 1);
        chk("simul_issue", bus.req_rd_en, 1'b1);
        chk("simul_resp_valid", bus.out_valid, 1'b1);
        chk("simul_resp_id", bus.out_id, 5);
        respond(m_last_tag);
        chk("simul_second_id", bus.out_id, 6);
        chk("simul_outstanding_0", outstanding, 0);

        // Response for a tag that is not in flight
        respond(2);
        chk("nonbusy_dropped", bus.out_valid, 1'b0);
        chk("nonbusy_err", err_spurious, 1'b1);

        // Reset with 10 outstanding, then a late response
        for (int i = 0; i < 10; i++) issue(48'h7000 + 48'(64 * i), i);
        chk("pre_reset_outstanding", outstanding, 10);
        reset = 1'b1;
        step(); step();
        chk("mid_reset_outstanding", outstanding, 0);
        chk("mid_reset_err_clear", err_spurious, 1'b0);
        chk("mid_reset_init_done", init_done, 1'b0);
        reset = 1'b0;
        wait_init();
        respond(5);
        chk("late_resp_dropped", bus.out_valid, 1'b0);
        chk("late_resp_err", err_spurious, 1'b1);

        // Upper mdata bits set on an otherwise busy tag
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init();
        issue(48'h2000, 6);
        chk("fresh_tag0", bus.req_rd_mdata, 0);
        respond(16'h0100);
        chk("upper_bits_dropped", bus.out_valid, 1'b0);
        chk("upper_bits_err", err_spurious, 1'b1);
        chk("upper_bits_still_busy", outstanding, 1);
        respond(0);
        chk("tag0_valid", bus.out_valid, 1'b1);
        chk("tag0_id", bus.out_id, 6);
        chk("final_outstanding", outstanding, 0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_tag_tracker.md
# rd_tag_tracker

Read-request tag tracker between a single requester port of `afu_manager`'s read path and the CCI-P c0 channel. It accepts byte-address read requests tagged with a requester ID, and assigns each one a free mdata tag from a pool of `MAX_OUTSTANDING`. It issues the request only when the channel is not almost-full. On each response it looks up the tag, returns the data with the original requester ID, and recycles the tag.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 64: tag pool size; power of two, 2..512.
- `ID_BITS`, 4: requester ID width.
- `ADDR_BITS`, 48: byte-address width (cache-line address plus 6 offset bits).
- `DATA_BITS`, 512: cache-line width.
- `MDATA_BITS`, 16: CCI mdata width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  read request offered.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_addr`  in  ADDR_BITS  byte address of the request; bits [5:0] are ignored.
- `in_id`  in  ID_BITS  requester ID.
- `req_rd_en`  out  1  issue read on c0.
- `req_rd_available`  in  1  `~c0TxAlmFull`.
- `req_rd_addr`  out  ADDR_BITS  byte address, low 6 bits forced to 0.
- `req_rd_mdata`  out  MDATA_BITS  tag, zero-extended.
- `resp_rd_valid`  in  1  read response present.
- `resp_rd_data`  in  DATA_BITS  response line.
- `resp_rd_mdata`  in  MDATA_BITS  response tag.
- `out_valid`  out  1  returned line valid; there is no backpressure.
- `out_data`  out  DATA_BITS  returned line.
- `out_id`  out  ID_BITS  requester ID of the returned line.
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  count of tags currently in flight.
- `init_done`  out  1  free list populated.
- `err_spurious`  out  1  sticky: a response arrived for a tag that is not in flight.

## Operation
- States: `INIT` and `RUN`.
- `INIT`:
  - Entered on reset.
  - A counter pushes tags 0..MAX_OUTSTANDING-1 into the free list, one per cycle.
  - The block moves to `RUN` after the last push.
  - `in_ready` = 0 throughout.
- `RUN`: `in_ready` = `req_rd_available && free_count != 0`. This is combinational; there is no dependence on `in_valid`.
- Accept:
  - Pop the tag at the free-list head.
  - Write `id_table[tag] <= in_id` and set `busy[tag] <= 1`.
  - Register `req_rd_en` = 1, `req_rd_addr`, and `req_rd_mdata` for exactly one cycle.
- Response:
  - Let `tag` = `resp_rd_mdata[$clog2(MAX_OUTSTANDING)-1:0]`.
  - The response is valid if `busy[tag]` is set and the upper mdata bits are 0.
  - If valid: register `out_valid` = 1, `out_data` = `resp_rd_data`, `out_id` = `id_table[tag]`. Clear `busy[tag]` and push `tag` to the free list.
  - If invalid: drop the response (`out_valid` = 0) and set `err_spurious`.
- Simultaneous accept and valid response in one cycle:
  - Pop and push both occur; `free_count` and `outstanding` are unchanged.
  - If the response frees the same tag index as the one being popped, this is impossible, because a popped tag is never busy.
- Free-list overflow is impossible: the push count is bounded by the number of busy tags.
- `outstanding` = MAX_OUTSTANDING − `free_count` in `RUN`, and 0 in `INIT`.
- Reset mid-operation: all tables, the free list, and flags are cleared, and the block re-enters `INIT`. Responses to pre-reset requests arriving after `INIT` completes are treated as spurious; they are dropped and set `err_spurious`.

## Timing
- Reset values of all outputs are 0: `in_ready`, `req_rd_en`, `req_rd_addr`, `req_rd_mdata`, `out_valid`, `out_data`, `out_id`, `outstanding`, `init_done`, `err_spurious`.
- `init_done` rises MAX_OUTSTANDING cycles after reset deasserts. `in_ready` can be 1 in that same cycle.
- Accept at cycle N gives `req_rd_en` = 1 at cycle N+1. This one-cycle slack is covered by the almost-full margin.
- `resp_rd_valid` at cycle N gives `out_valid` = 1 at cycle N+1. A tag freed at N can be popped at N+1.
- Sustained throughput is one request per cycle and one response per cycle.

## Structure
- Package `rd_tag_pkg`:
  - `MAX_OUTSTANDING` default.
  - `TAG_BITS` = $clog2(MAX_OUTSTANDING).
  - `t_tag` typedef.
  - State enum `{ST_INIT, ST_RUN}`.
- Sub-module `rd_tag_freelist`:
  - Circular FIFO of `t_tag`, depth MAX_OUTSTANDING.
  - Ports: push, push_tag, pop, head_tag, count.
  - Handles simultaneous push and pop.
- Top level holds `id_table`, the `busy` vector, the FSM, and the output registers.

## Test plan
- Reset, then idle: `init_done` = 1 exactly 64 cycles after reset falls, `outstanding` = 0, first accepted request gets `req_rd_mdata` = 0.
- Address handling: 4 back-to-back requests with IDs 1,2,3,4 and addr 0x1000+64·k.
  - Required issue: tags 0..3, addresses 0x1000/1040/1080/10C0, `outstanding` = 4.
  - Then respond to tags 3,0,2,1: `out_id` is 4,1,3,2 in that order, and `outstanding` returns to 0.
- Exhaustion: issue 64 requests with no responses. Required: `in_ready` = 0 with `outstanding` = 64. One response makes `in_ready` = 1 next cycle, and the next request reuses that tag.
- Backpressure: hold `req_rd_available` = 0 with `in_valid` = 1. Required: no `req_rd_en` and no tag consumed. Releasing it yields an issue on the following cycle.
- Simultaneous events and spurious response:
  - Accept and a response in the same cycle leave `outstanding` unchanged.
  - A response with mdata 0x0100 (upper mdata bits nonzero) or a non-busy tag gives `out_valid` = 0 and `err_spurious` = 1.
- Reset mid-run with 10 outstanding: required `outstanding` = 0 and re-init over 64 cycles. A late response for tag 5 is dropped and sets `err_spurious`.
